// File: rtl/sprite_pixel_pipe_if.sv
// Pixel stream from the VGA sync counter in, registered DAC colour out.
// master = sync/DAC side, slave = sprite_pixel_pipe.
interface sprite_pixel_pipe_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    modport master (
        output pixel_x, pixel_y, video_on,
        input  red, green, blue
    );

    modport slave (
        input  pixel_x, pixel_y, video_on,
        output red, green, blue
    );
endinterface

// File: rtl/sprite_pixel_pipe.sv
// Three-stage pixel generator: border, player disc, enemy discs,
// plus per-frame player/enemy overlap reporting.
module sprite_pixel_pipe #(
    parameter int N_ENEMY = 3,
    parameter int ENEMY_R = 10,
    parameter int BORDER  = 15,
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480
) (
    input  logic                   clk_d,
    input  logic                   reset,
    sprite_pixel_pipe_if.slave     vga,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic [5:0]             r,
    input  logic [10*N_ENEMY-1:0]  enemy_x,
    input  logic [10*N_ENEMY-1:0]  enemy_y,
    input  logic [N_ENEMY-1:0]     enemy_en,
    input  logic                   gamemenu,
    input  logic                   gamepause,
    input  logic                   gamerun,
    output logic [N_ENEMY-1:0]     hit_vec,
    output logic                   hit_valid
);

    localparam logic [11:0] ER2 = 12'(ENEMY_R * ENEMY_R);

    // Zero-extend both operands so off-screen centres cannot wrap.
    function automatic logic [10:0] diff(input logic [9:0] a, input logic [9:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [20:0] dist2(input logic [10:0] dx, input logic [10:0] dy);
        logic [10:0] ax;
        logic [10:0] ay;
        logic [19:0] sx;
        logic [19:0] sy;
        ax = dx[10] ? 11'(-dx) : dx;
        ay = dy[10] ? 11'(-dy) : dy;
        sx = {10'd0, ax[9:0]} * {10'd0, ax[9:0]};
        sy = {10'd0, ay[9:0]} * {10'd0, ay[9:0]};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    logic border;
    logic frame_end;

    assign border = (vga.pixel_x < 10'(BORDER))
                  | (vga.pixel_x >= 10'(H_ACT - BORDER))
                  | (vga.pixel_y < 10'(BORDER))
                  | (vga.pixel_y >= 10'(V_ACT - BORDER));
    assign frame_end = (vga.pixel_x == 10'(H_ACT - 1))
                     & (vga.pixel_y == 10'(V_ACT - 1));

    logic [10:0]              pdx1, pdy1;
    logic [N_ENEMY-1:0][10:0] edx1, edy1;
    logic [11:0]              rr1;
    logic                     v1, bd1, fe1, gm1, gp1, gr1;
    logic [N_ENEMY-1:0]       en1;

    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            pdx1 <= '0;
            pdy1 <= '0;
            edx1 <= '0;
            edy1 <= '0;
            rr1  <= '0;
            v1   <= 1'b0;
            bd1  <= 1'b0;
            fe1  <= 1'b0;
            gm1  <= 1'b0;
            gp1  <= 1'b0;
            gr1  <= 1'b0;
            en1  <= '0;
        end else begin
            pdx1 <= diff(vga.pixel_x, x);
            pdy1 <= diff(vga.pixel_y, y);
            for (int k = 0; k < N_ENEMY; k++) begin
                edx1[k] <= diff(vga.pixel_x, enemy_x[10*k +: 10]);
                edy1[k] <= diff(vga.pixel_y, enemy_y[10*k +: 10]);
            end
            rr1 <= {6'd0, r} * {6'd0, r};
            v1  <= vga.video_on;
            bd1 <= border;
            fe1 <= frame_end;
            gm1 <= gamemenu;
            gp1 <= gamepause;
            gr1 <= gamerun;
            en1 <= enemy_en;
        end
    end

    logic [20:0]              psq2;
    logic [N_ENEMY-1:0][20:0] esq2;
    logic [11:0]              rr2;
    logic                     v2, bd2, fe2, gm2, gp2, gr2;
    logic [N_ENEMY-1:0]       en2;

    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            psq2 <= '0;
            esq2 <= '0;
            rr2  <= '0;
            v2   <= 1'b0;
            bd2  <= 1'b0;
            fe2  <= 1'b0;
            gm2  <= 1'b0;
            gp2  <= 1'b0;
            gr2  <= 1'b0;
            en2  <= '0;
        end else begin
            psq2 <= dist2(pdx1, pdy1);
            for (int k = 0; k < N_ENEMY; k++)
                esq2[k] <= dist2(edx1[k], edy1[k]);
            rr2 <= rr1;
            v2  <= v1;
            bd2 <= bd1;
            fe2 <= fe1;
            gm2 <= gm1;
            gp2 <= gp1;
            gr2 <= gr1;
            en2 <= en1;
        end
    end

    logic               in_p;
    logic [N_ENEMY-1:0] in_e;
    logic [N_ENEMY-1:0] hit_now;
    logic [N_ENEMY-1:0] hit_acc;

    always_comb begin
        in_p = (psq2 <= {9'd0, rr2});
        for (int k = 0; k < N_ENEMY; k++)
            in_e[k] = en2[k] & (esq2[k] <= {9'd0, ER2});
        hit_now = (v2 & ~bd2 & in_p) ? in_e : '0;
    end

    always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
            vga.red   <= '0;
            vga.green <= '0;
            vga.blue  <= '0;
            hit_acc   <= '0;
            hit_vec   <= '0;
            hit_valid <= 1'b0;
        end else begin
            if (!v2) begin
                vga.red   <= '0;
                vga.green <= '0;
                vga.blue  <= '0;
            end else if (bd2) begin
                vga.red   <= {4{gm2}};
                vga.green <= {4{gp2}};
                vga.blue  <= {4{gr2}};
            end else begin
                vga.red   <= {4{in_p}};
                vga.green <= {4{|in_e}};
                vga.blue  <= '0;
            end
            // The frame-end pixel's own hit lands in this frame's report.
            if (v2 && fe2) begin
                hit_vec   <= hit_acc | hit_now;
                hit_valid <= 1'b1;
                hit_acc   <= '0;
            end else begin
                hit_acc   <= hit_acc | hit_now;
                hit_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Directed checks of sprite_pixel_pipe: latency, border, discs,
// enable mask, collision reporting and asynchronous reset.
module tb_sprite_pixel_pipe;

    logic        clk_d = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic [5:0]  r;
    logic [29:0] enemy_x, enemy_y;
    logic [2:0]  enemy_en;
    logic        gamemenu, gamepause, gamerun;
    logic [2:0]  hit_vec;
    logic        hit_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_d = ~clk_d;

    sprite_pixel_pipe_if vif ();

    sprite_pixel_pipe dut (
        .clk_d     (clk_d),
        .reset     (reset),
        .vga       (vif.slave),
        .x         (x),
        .y         (y),
        .r         (r),
        .enemy_x   (enemy_x),
        .enemy_y   (enemy_y),
        .enemy_en  (enemy_en),
        .gamemenu  (gamemenu),
        .gamepause (gamepause),
        .gamerun   (gamerun),
        .hit_vec   (hit_vec),
        .hit_valid (hit_valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic px(input logic [9:0] a, input logic [9:0] b, input logic v);
        @(negedge clk_d);
        vif.pixel_x  = a;
        vif.pixel_y  = b;
        vif.video_on = v;
    endtask

    task automatic idle();
        px(10'd0, 10'd0, 1'b0);
    endtask

    function automatic logic [11:0] rgb();
        return {vif.red, vif.green, vif.blue};
    endfunction

    task automatic probe(input string tag, input logic [9:0] a,
                         input logic [9:0] b, input logic v,
                         input logic [11:0] exp);
        px(a, b, v);
        idle();
        idle();
        @(posedge clk_d);
        #1 check(tag, 32'(rgb()), 32'(exp));
    endtask

    task automatic frame_end(input string tag, input logic [2:0] exp);
        px(10'd639, 10'd479, 1'b1);
        idle();
        idle();
        @(posedge clk_d);
        #1;
        check({tag, "_valid"}, 32'(hit_valid), 32'd1);
        check({tag, "_vec"}, 32'(hit_vec), 32'(exp));
        @(posedge clk_d);
        #1;
        check({tag, "_drop"}, 32'(hit_valid), 32'd0);
        check({tag, "_hold"}, 32'(hit_vec), 32'(exp));
    endtask

    initial begin
        reset        = 1'b1;
        vif.pixel_x  = '0;
        vif.pixel_y  = '0;
        vif.video_on = 1'b0;
        x = 10'd320; y = 10'd240; r = 6'd20;
        enemy_x  = {10'd0, 10'd400, 10'd120};
        enemy_y  = {10'd0, 10'd400, 10'd100};
        enemy_en = 3'b000;
        gamemenu = 1'b0; gamepause = 1'b0; gamerun = 1'b0;
        repeat (3) @(posedge clk_d);
        #1;
        check("rst_rgb", 32'(rgb()), 32'h0);
        check("rst_hvec", 32'(hit_vec), 32'h0);
        check("rst_hval", 32'(hit_valid), 32'h0);
        @(negedge clk_d);
        reset = 1'b0;

        // Latency: centre pixel must not show after 2 edges, must after 3.
        px(10'd320, 10'd240, 1'b1);
        idle();
        @(posedge clk_d);
        #1 check("lat_early", 32'(rgb()), 32'h000);
        idle();
        @(posedge clk_d);
        #1 check("lat_exact", 32'(rgb()), 32'hF00);
        probe("rad_edge", 10'd340, 10'd240, 1'b1, 12'hF00);
        probe("rad_out", 10'd341, 10'd240, 1'b1, 12'h000);
        probe("vid_off", 10'd320, 10'd240, 1'b0, 12'h000);

        // Border overrides the player.
        x = 10'd5; y = 10'd100; gamepause = 1'b1;
        probe("brd_pause", 10'd5, 10'd100, 1'b1, 12'h0F0);
        probe("brd_inner", 10'd15, 10'd100, 1'b1, 12'hF00);
        gamepause = 1'b0; gamemenu = 1'b1; gamerun = 1'b1;
        probe("brd_menu_run", 10'd5, 10'd100, 1'b1, 12'hF0F);
        probe("brd_bottom", 10'd300, 10'd465, 1'b1, 12'hF0F);
        gamemenu = 1'b0; gamerun = 1'b0;

        // Overlap and collision reporting.
        x = 10'd100; y = 10'd100; r = 6'd30; enemy_en = 3'b011;
        probe("ovl_yellow", 10'd110, 10'd100, 1'b1, 12'hFF0);
        probe("en1_green", 10'd400, 10'd400, 1'b1, 12'h0F0);
        check("hval_quiet", 32'(hit_valid), 32'h0);
        frame_end("fe_hit", 3'b001);

        // Reset mid-frame with a pending hit and a non-zero colour.
        probe("pre_rst", 10'd115, 10'd100, 1'b1, 12'hFF0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rgb", 32'(rgb()), 32'h0);
        check("mid_rst_hvec", 32'(hit_vec), 32'h0);
        check("mid_rst_hval", 32'(hit_valid), 32'h0);
        repeat (2) @(posedge clk_d);
        @(negedge clk_d);
        reset = 1'b0;
        repeat (4) idle();
        check("post_rst_hval", 32'(hit_valid), 32'h0);
        frame_end("fe_after_rst", 3'b000);

        // Enable mask: enemy0 disabled draws and collides with nothing.
        enemy_en = 3'b110;
        probe("mask_no_green", 10'd120, 10'd100, 1'b1, 12'hF00);
        probe("mask_en1", 10'd400, 10'd400, 1'b1, 12'h0F0);
        probe("mask_ovl", 10'd115, 10'd100, 1'b1, 12'hF00);
        frame_end("fe_mask", 3'b000);

        // Signed distance, no unsigned wrap; r=0 lights only the centre.
        enemy_en = 3'b000;
        x = 10'd5; y = 10'd5; r = 6'd50;
        probe("wrap_far", 10'd630, 10'd470, 1'b1, 12'h000);
        probe("wrap_in", 10'd40, 10'd40, 1'b1, 12'hF00);
        r = 6'd63;
        probe("wrap_far2", 10'd600, 10'd400, 1'b1, 12'h000);
        x = 10'd200; y = 10'd200; r = 6'd0;
        probe("r0_ctr", 10'd200, 10'd200, 1'b1, 12'hF00);
        probe("r0_right", 10'd201, 10'd200, 1'b1, 12'h000);
        probe("r0_up", 10'd200, 10'd199, 1'b1, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
